mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared transmission-gate 4:1 mux. Four requesters contend for the single mux output. The block grants one requester at a time and drives the mux selects `s1:s0`. It waits one settle cycle for the pass-transistor path, then samples the mux output into a registered `data_out` with a `valid` strobe for a bounded burst. It sits between the requester logic and the mux datapath. It is the only driver of the mux select lines.

---
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and select sequencer for a shared 4:1 transmission-gate mux.
// Optional feature: define MUX_ARB_LOCK_EN to add the lock port that extends the current grant.
module mux4_rr_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mux_in,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       data_out
);
    typedef enum logic [1:0] {IDLE, SETTLE, XFER} state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n, sel, sel_n, win;
    logic [3:0] cnt, cnt_n, gnt_n;
    logic       valid_n, data_n, gnt_req, hold_lock;

    assign s1      = sel[1];
    assign s0      = sel[0];
    assign gnt_req = |(req & gnt);
`ifdef MUX_ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    // Round-robin pick: lowest k such that req[(ptr+k)%4] is high wins.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end

    // Next-state and next-output logic; release clears the grant and advances the pointer.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        cnt_n   = cnt;
        ptr_n   = ptr;
        valid_n = 1'b0;
        data_n  = data_out;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_n   = 4'b0001 << win;
                    sel_n   = win;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (!gnt_req) begin
                    gnt_n   = 4'b0000;
                    ptr_n   = sel + 2'd1;
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n   = 4'(HOLD_CYCLES);
                    state_n = XFER;
                end
            end
            XFER: begin
                if (!gnt_req || (cnt <= 4'd1 && !hold_lock)) begin
                    gnt_n   = 4'b0000;
                    ptr_n   = sel + 2'd1;
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = (cnt <= 4'd1) ? 4'd1 : cnt - 4'd1;
                end
                if (gnt_req) begin
                    data_n  = mux_in;
                    valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            cnt      <= 4'd0;
            ptr      <= 2'd0;
            valid    <= 1'b0;
            data_out <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
            valid    <= valid_n;
            data_out <= data_n;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: randomized self-checking bench with a transaction-level arbiter model.
module tb_mux4_rr_arbiter;
    localparam int H = 2;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk, rst_n, mux_in, lock, s0, s1, valid, data_out;
    logic [3:0] req, gnt;
    int         tests, fails, m_ptr;

    mux4_rr_arbiter #(.HOLD_CYCLES(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .mux_in(mux_in),
`ifdef MUX_ARB_LOCK_EN
        .lock(lock),
`endif
        .s0(s0),
        .s1(s1),
        .gnt(gnt),
        .valid(valid),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] r, int p);
        int res;
        res = -1;
        for (int k = 0; k < 4; k++)
            if (res < 0 && r[(p + k) % 4]) res = (p + k) % 4;
        return res;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0;
        lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // One full grant from an IDLE negedge; drop_at = sample index before which the winner drops req.
    task automatic run_grant(input logic [3:0] r, input int drop_at, input int lock_len, output int w);
        int   n;
        logic m;
        w = pick(r, m_ptr);
        n = H;
        if (LOCK_EN && lock_len + 1 > n) n = lock_len + 1;
        req = r;
        @(negedge clk);
        tests++;
        if (gnt !== 4'(1 << w) || {s1, s0} !== 2'(w) || valid !== 1'b0) begin
            fails++;
            $display("FAIL grant req=%b: gnt=%b sel=%0d valid=%b, expected gnt=%b sel=%0d valid=0",
                     r, gnt, {s1, s0}, valid, 4'(1 << w), w);
        end
        if (drop_at == 0) req = r & ~4'(1 << w);
        mux_in = 1'($urandom);
        @(negedge clk);
        if (drop_at == 0) begin
            tests++;
            if (gnt !== 4'b0 || valid !== 1'b0) begin
                fails++;
                $display("FAIL settle_drop: gnt=%b valid=%b, expected gnt=0000 valid=0", gnt, valid);
            end
            m_ptr = (w + 1) % 4;
            return;
        end
        tests++;
        if (gnt !== 4'(1 << w) || {s1, s0} !== 2'(w) || valid !== 1'b0) begin
            fails++;
            $display("FAIL settle: gnt=%b sel=%0d valid=%b, expected gnt=%b sel=%0d valid=0",
                     gnt, {s1, s0}, valid, 4'(1 << w), w);
        end
        for (int s = 0; s < n; s++) begin
            if (s == drop_at) begin
                req = r & ~4'(1 << w);
                lock = 1'b0;
                @(negedge clk);
                tests++;
                if (gnt !== 4'b0 || valid !== 1'b0) begin
                    fails++;
                    $display("FAIL early_drop s=%0d: gnt=%b valid=%b, expected gnt=0000 valid=0", s, gnt, valid);
                end
                m_ptr = (w + 1) % 4;
                return;
            end
            m = 1'($urandom);
            mux_in = m;
            lock = (s < lock_len);
            @(negedge clk);
            tests++;
            if (valid !== 1'b1 || data_out !== m || {s1, s0} !== 2'(w) ||
                gnt !== ((s == n - 1) ? 4'b0 : 4'(1 << w))) begin
                fails++;
                $display("FAIL sample %0d/%0d: valid=%b data=%b gnt=%b sel=%0d, expected valid=1 data=%b gnt=%b sel=%0d",
                         s, n, valid, data_out, gnt, {s1, s0}, m, (s == n - 1) ? 4'b0 : 4'(1 << w), w);
            end
        end
        lock = 1'b0;
        m_ptr = (w + 1) % 4;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req = 4'b0;
        mux_in = 1'b0;
        lock = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({s1, s0, gnt, valid, data_out} !== 8'b0) begin
            fails++;
            $display("FAIL reset: s1s0=%b%b gnt=%b valid=%b data=%b, expected all 0", s1, s0, gnt, valid, data_out);
        end
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_single();
        int w;
        run_grant(4'b0001, 99, 0, w);
        tests++;
        if (w != 0) begin fails++; $display("FAIL single_winner: got %0d, expected 0", w); end
        run_grant(4'b1111, 99, 0, w);
        tests++;
        if (w != 1) begin fails++; $display("FAIL ptr_after_0: got %0d, expected 1", w); end
    endtask

    task automatic test_fairness();
        int w;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_grant(4'b1111, 99, 0, w);
            tests++;
            if (w != i % 4) begin fails++; $display("FAIL fair_order %0d: got %0d, expected %0d", i, w, i % 4); end
        end
    endtask

    task automatic test_early_drop();
        int w;
        do_reset();
        run_grant(4'b1100, 1, 0, w);
        tests++;
        if (w != 2) begin fails++; $display("FAIL drop_winner: got %0d, expected 2", w); end
        run_grant(4'b1000, 99, 0, w);
        tests++;
        if (w != 3) begin fails++; $display("FAIL after_drop: got %0d, expected 3", w); end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        req = 4'b0010;
        mux_in = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (valid !== 1'b1 || data_out !== 1'b1 || gnt !== 4'b0010) begin
            fails++;
            $display("FAIL mid_pre: valid=%b data=%b gnt=%b, expected 1 1 0010", valid, data_out, gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({s1, s0, gnt, valid, data_out} !== 8'b0) begin
            fails++;
            $display("FAIL mid_reset: s1s0=%b%b gnt=%b valid=%b data=%b, expected all 0", s1, s0, gnt, valid, data_out);
        end
        req = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        run_grant(4'b1000, 99, 0, w);
        tests++;
        if ({s1, s0} !== 2'b11) begin fails++; $display("FAIL post_reset_sel: got %b%b, expected 11", s1, s0); end
    endtask

    task automatic test_lock();
        int w;
        do_reset();
        run_grant(4'b0010, 99, 6, w);
        tests++;
        if (w != 1) begin fails++; $display("FAIL lock_winner: got %0d, expected 1", w); end
    endtask

    task automatic test_random();
        int w, d, ll;
        logic [3:0] r;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom);
            if (r == 4'b0) begin
                req = 4'b0;
                @(negedge clk);
                tests++;
                if (gnt !== 4'b0 || valid !== 1'b0) begin
                    fails++;
                    $display("FAIL idle: gnt=%b valid=%b, expected 0000 0", gnt, valid);
                end
            end else begin
                d = $urandom_range(0, H + 2);
                ll = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
                run_grant(r, d, ll, w);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_fairness();
        test_early_drop();
        test_reset_mid();
        test_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
